// File: rtl/ir_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// ir_fetch_sequencer
//
// Fetches one two-byte, big-endian instruction into the instruction
// register. The upper byte is read from the program counter address A and
// the lower byte from A+1. The block then pulses ir_valid for one cycle.
// Each byte read waits on mem_ready and is bounded by TIMEOUT wait cycles.
// When the bound expires the block parks in an error state. A later start
// retries the whole instruction from its original address.
//
// Parameters
//   ADDR_W    width of the program counter and the memory address
//   TIMEOUT   maximum consecutive wait cycles per byte read (>= 1)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      request a fetch of the next instruction
//   pc_load    load pc from pc_in (jump); honoured only while not busy
//   pc_in      jump target
//   mem_ready  memory data register holds valid read data this cycle
//   mem_rd     memory read request
//   mem_addr   memory read address (always equal to pc)
//   load_iru   load the IR upper byte from the memory data register
//   load_irl   load the IR lower byte from the memory data register
//   ir_valid   one-cycle pulse: the IR holds a complete instruction
//   busy       a fetch is in progress
//   fetch_err  a read timed out; held until the next start
//   pc         current program counter
// ---------------------------------------------------------------------------
module ir_fetch_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              mem_ready,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              load_iru,
  output logic              load_irl,
  output logic              ir_valid,
  output logic              busy,
  output logic              fetch_err,
  output logic [ADDR_W-1:0] pc
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // The counter value seen in the TIMEOUT-th consecutive wait cycle.
  // If mem_ready is still low in that cycle, the read has timed out.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    RD_U,
    RD_L,
    DONE,
    ERR
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc_next;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_cnt_next;
  logic              timed_out;

  assign timed_out = (wait_cnt == WAIT_LAST);

  // The address comes from the registered pc, never from pc_in directly.
  // A jump therefore takes effect one cycle later, on the first read.
  assign mem_addr = pc;

  // NOTE: sequential state uses non-blocking assignments only.
  // Every register then samples values from before the clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      pc       <= '0;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      pc       <= pc_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // NOTE: every signal gets a default before the case statement.
  // This stops latches from being inferred on paths that do not assign it.
  // It also clears wait_cnt on any exit from a read state.
  always_comb begin
    state_next    = state;
    pc_next       = pc;
    wait_cnt_next = '0;
    mem_rd        = 1'b0;
    load_iru      = 1'b0;
    load_irl      = 1'b0;
    ir_valid      = 1'b0;
    busy          = 1'b0;
    fetch_err     = 1'b0;

    unique case (state)
      IDLE: begin
        if (pc_load) pc_next = pc_in;
        if (start)   state_next = RD_U;
      end

      RD_U: begin
        mem_rd = 1'b1;
        busy   = 1'b1;
        if (mem_ready) begin
          load_iru   = 1'b1;
          pc_next    = pc + ADDR_W'(1);
          state_next = RD_L;
        end else if (timed_out) begin
          state_next = ERR;
        end else begin
          wait_cnt_next = wait_cnt + CNT_W'(1);
        end
      end

      RD_L: begin
        mem_rd = 1'b1;
        busy   = 1'b1;
        if (mem_ready) begin
          load_irl   = 1'b1;
          pc_next    = pc + ADDR_W'(1);
          state_next = DONE;
        end else if (timed_out) begin
          // pc already advanced past the upper byte. Step it back so a
          // retry starts from the instruction's first byte.
          pc_next    = pc - ADDR_W'(1);
          state_next = ERR;
        end else begin
          wait_cnt_next = wait_cnt + CNT_W'(1);
        end
      end

      DONE: begin
        ir_valid = 1'b1;
        if (pc_load) pc_next = pc_in;
        state_next = start ? RD_U : IDLE;
      end

      ERR: begin
        fetch_err = 1'b1;
        if (pc_load) pc_next = pc_in;
        if (start)   state_next = RD_U;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ir_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ir_fetch_sequencer
//
// Directed bench with hand-computed expectations. u_dut uses TIMEOUT=15
// and covers the normal fetch, jump, wrap, wait, ignored-jump and reset
// cases. u_dut_t4 uses TIMEOUT=4 and covers the timeout, error and retry
// case. Inputs change 1 time unit after each rising edge. Outputs are
// sampled 1 time unit later, well before the falling edge.
// ---------------------------------------------------------------------------
module tb_ir_fetch_sequencer;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;

  logic              start, pc_load, mem_ready;
  logic [ADDR_W-1:0] pc_in;
  logic              mem_rd, load_iru, load_irl, ir_valid, busy, fetch_err;
  logic [ADDR_W-1:0] mem_addr, pc;

  logic              start4, pc_load4, mem_ready4;
  logic [ADDR_W-1:0] pc_in4;
  logic              mem_rd4, load_iru4, load_irl4, ir_valid4, busy4, fetch_err4;
  logic [ADDR_W-1:0] mem_addr4, pc4;

  logic [7:0]        mem [256];
  logic [15:0]       ir;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ir_fetch_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(15)) u_dut (
    .clk(clk), .reset(reset), .start(start), .pc_load(pc_load),
    .pc_in(pc_in), .mem_ready(mem_ready), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .load_iru(load_iru), .load_irl(load_irl),
    .ir_valid(ir_valid), .busy(busy), .fetch_err(fetch_err), .pc(pc)
  );

  ir_fetch_sequencer #(.ADDR_W(ADDR_W), .TIMEOUT(4)) u_dut_t4 (
    .clk(clk), .reset(reset), .start(start4), .pc_load(pc_load4),
    .pc_in(pc_in4), .mem_ready(mem_ready4), .mem_rd(mem_rd4),
    .mem_addr(mem_addr4), .load_iru(load_iru4), .load_irl(load_irl4),
    .ir_valid(ir_valid4), .busy(busy4), .fetch_err(fetch_err4), .pc(pc4)
  );

  // Instruction register model fed by the memory data at mem_addr.
  always @(posedge clk) begin
    if (load_iru) ir[15:8] <= mem[mem_addr];
    if (load_irl) ir[7:0]  <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic st, input logic pl, input logic [ADDR_W-1:0] pin,
                       input logic rdy);
    start = st; pc_load = pl; pc_in = pin; mem_ready = rdy;
    #1;
  endtask

  task automatic drive4(input logic st, input logic pl, input logic [ADDR_W-1:0] pin,
                        input logic rdy);
    start4 = st; pc_load4 = pl; pc_in4 = pin; mem_ready4 = rdy;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h00] = 8'h12; mem[8'h01] = 8'h34; mem[8'h02] = 8'h56;
    mem[8'h03] = 8'h9A; mem[8'h04] = 8'hBC;
    mem[8'h05] = 8'hDE; mem[8'h06] = 8'hAD;
    mem[8'h07] = 8'h77; mem[8'hFF] = 8'hAB;
    ir = 16'h0000;

    // ---- reset values ----
    reset = 1'b0;
    drive(0, 0, '0, 0);
    drive4(0, 0, '0, 0);
    check("rst_outs", {mem_rd, load_iru, load_irl, ir_valid, busy, fetch_err}, 6'b0);
    check("rst_pc", pc, 8'h00);
    check("rst_addr", mem_addr, 8'h00);
    tick();
    reset = 1'b1;
    tick();

    // ---- TIMEOUT=4: lower-byte timeout, error, then full retry ----
    drive4(1, 1, 8'h20, 0);
    tick();
    drive4(0, 0, '0, 1);
    check("t4_iru", load_iru4, 1);
    check("t4_iru_addr", mem_addr4, 8'h20);
    tick();
    for (int c = 0; c < 4; c++) begin
      drive4(0, 0, '0, 0);
      check("t4_wait_rd", {mem_rd4, load_irl4, fetch_err4}, 3'b100);
      check("t4_wait_addr", mem_addr4, 8'h21);
      tick();
    end
    drive4(0, 0, '0, 1);
    check("t4_err", {fetch_err4, busy4, mem_rd4, load_iru4, load_irl4}, 5'b10000);
    check("t4_err_pc", pc4, 8'h20);
    check("t4_err_addr", mem_addr4, 8'h20);
    tick();
    drive4(1, 0, '0, 0);
    check("t4_err_hold", fetch_err4, 1);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive4(0, 0, '0, 0);
      check("t4_retry_wait", {mem_rd4, load_iru4, fetch_err4}, 3'b100);
      check("t4_retry_addr", mem_addr4, 8'h20);
      tick();
    end
    drive4(0, 0, '0, 1);
    check("t4_last_cycle_ok", load_iru4, 1);
    tick();
    drive4(0, 0, '0, 1);
    check("t4_retry_irl", {load_irl4, load_iru4}, 2'b10);
    check("t4_retry_irl_addr", mem_addr4, 8'h21);
    tick();
    drive4(0, 0, '0, 0);
    check("t4_retry_valid", ir_valid4, 1);
    check("t4_retry_pc", pc4, 8'h22);
    tick();

    // ---- zero-wait fetch from 0 ----
    drive(1, 0, '0, 0);
    check("idle_busy", busy, 0);
    tick();
    drive(0, 0, '0, 1);
    check("c1_iru", {load_iru, load_irl, mem_rd, busy}, 4'b1011);
    check("c1_addr", mem_addr, 8'h00);
    tick();
    drive(0, 0, '0, 1);
    check("c2_irl", {load_iru, load_irl}, 2'b01);
    check("c2_addr", mem_addr, 8'h01);
    tick();
    drive(0, 0, '0, 0);
    check("c3_valid", {ir_valid, busy}, 2'b10);
    check("c3_pc", pc, 8'h02);
    check("c3_ir", ir, 16'h1234);
    tick();
    check("idle_no_valid", ir_valid, 0);

    // ---- jump with start, wrap, then back-to-back ----
    drive(1, 1, 8'hFF, 0);
    tick();
    drive(0, 0, '0, 1);
    check("jmp_iru", load_iru, 1);
    check("jmp_addr_u", mem_addr, 8'hFF);
    tick();
    drive(0, 0, '0, 1);
    check("jmp_irl", load_irl, 1);
    check("wrap_addr_l", mem_addr, 8'h00);
    tick();
    drive(1, 0, '0, 0);
    check("wrap_valid", ir_valid, 1);
    check("wrap_pc", pc, 8'h01);
    check("wrap_ir", ir, 16'hAB12);
    tick();
    drive(0, 0, '0, 1);
    check("b2b_iru", load_iru, 1);
    check("b2b_addr_u", mem_addr, 8'h01);
    tick();
    drive(0, 0, '0, 1);
    check("b2b_irl", load_irl, 1);
    tick();
    drive(0, 0, '0, 0);
    check("b2b_valid", ir_valid, 1);
    check("b2b_ir", ir, 16'h3456);
    check("b2b_pc", pc, 8'h03);
    tick();

    // ---- three wait cycles on the upper byte ----
    drive(1, 0, '0, 0);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, '0, 0);
      check("wt_hold", {mem_rd, load_iru, load_irl}, 3'b100);
      check("wt_addr", mem_addr, 8'h03);
      tick();
    end
    drive(0, 0, '0, 1);
    check("wt_iru_c4", load_iru, 1);
    tick();
    drive(0, 0, '0, 1);
    check("wt_irl_c5", {load_irl, load_iru}, 2'b10);
    tick();
    drive(0, 0, '0, 0);
    check("wt_valid_c6", ir_valid, 1);
    check("wt_ir", ir, 16'h9ABC);
    tick();

    // ---- pc_load ignored while busy ----
    drive(1, 0, '0, 0);
    tick();
    drive(0, 1, 8'h40, 0);
    check("busy_jmp_addr1", mem_addr, 8'h05);
    tick();
    drive(0, 1, 8'h40, 1);
    check("busy_jmp_addr2", mem_addr, 8'h05);
    check("busy_jmp_iru", load_iru, 1);
    tick();
    drive(0, 1, 8'h40, 1);
    check("busy_jmp_addr3", mem_addr, 8'h06);
    tick();
    drive(0, 0, '0, 0);
    check("busy_jmp_pc", pc, 8'h07);
    check("busy_jmp_ir", ir, 16'hDEAD);
    tick();

    // ---- reset asserted in RD_L aborts the fetch ----
    drive(1, 0, '0, 0);
    tick();
    drive(0, 0, '0, 1);
    tick();
    drive(0, 0, '0, 0);
    check("rl_before_rst", {mem_rd, busy}, 2'b11);
    reset = 1'b0;
    #1;
    check("rl_rst_outs", {mem_rd, load_iru, load_irl, ir_valid, busy, fetch_err}, 6'b0);
    check("rl_rst_pc", pc, 8'h00);
    drive(0, 0, '0, 1);
    check("rl_rst_no_irl", load_irl, 0);
    tick();
    reset = 1'b1;
    drive(0, 0, '0, 0);
    tick();
    drive(1, 0, '0, 0);
    tick();
    drive(0, 0, '0, 1);
    check("post_rst_addr", mem_addr, 8'h00);
    check("post_rst_iru", load_iru, 1);
    tick();
    drive(0, 0, '0, 1);
    tick();
    drive(0, 0, '0, 0);
    check("post_rst_ir", ir, 16'h1234);
    check("post_rst_pc", pc, 8'h02);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ir_fetch_sequencer.md
# ir_fetch_sequencer

Controller that sequences two-byte instruction fetches into the instruction register. It drives the memory read address from an internal program counter and waits on a memory ready handshake. It pulses the instruction register's upper-load and lower-load strobes in order, then flags a complete instruction to decode. It sits between the program counter / memory interface and the instruction register, replacing manual load switches.

## Interface
- ADDR_W, 8, width of program counter and memory address
- TIMEOUT, 15, max consecutive wait cycles per byte read before error (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  request fetch of next instruction
- pc_load  in  1  load PC from pc_in (jump)
- pc_in  in  ADDR_W  jump target
- mem_ready  in  1  MDR holds valid read data this cycle
- mem_rd  out  1  memory read request
- mem_addr  out  ADDR_W  memory read address
- load_iru  out  1  load IR upper byte from MDR
- load_irl  out  1  load IR lower byte from MDR
- ir_valid  out  1  one-cycle pulse: IR holds complete instruction
- busy  out  1  fetch in progress
- fetch_err  out  1  read timed out; held until restart
- pc  out  ADDR_W  current program counter

## Operation
- States: IDLE, RD_U, RD_L, DONE, ERR.
- IDLE: busy=0.
  - start=1 → RD_U.
  - pc_load=1 → pc←pc_in.
  - Both in the same cycle: pc loaded, and the fetch uses the new pc.
- RD_U: mem_rd=1, mem_addr=pc, busy=1.
  - mem_ready=1: load_iru=1 same cycle (Mealy), pc←pc+1, → RD_L.
- RD_L: mem_rd=1, mem_addr=pc, busy=1.
  - mem_ready=1: load_irl=1 same cycle, pc←pc+1, → DONE.
- Byte order is big-endian: the upper byte comes from the fetch-start address A, the lower byte from A+1.
- DONE: ir_valid=1, busy=0.
  - start=1 → RD_U (back-to-back); else → IDLE.
  - pc_load honoured as in IDLE.
- Timeout: a wait counter clears on every entry to RD_U or RD_L and increments each cycle that mem_ready=0 in that state.
  - mem_ready=0 in the TIMEOUT-th consecutive cycle → ERR; no load strobe; pc unchanged.
  - mem_ready=1 in cycle TIMEOUT is still accepted.
- ERR: fetch_err=1, busy=0, mem_rd=0.
  - start=1 → clear fetch_err, → RD_U and retry the full instruction from the address it started at. On an RD_L timeout, pc is rewound by 1.
  - pc_load honoured.
- pc_load and pc_in are ignored while busy=1.
- mem_ready is ignored outside RD_U/RD_L.
- pc wraps modulo 2^ADDR_W (all-ones +1 → 0).
- load_iru and load_irl are never both 1, and are never 1 when mem_ready=0.
- Counter width is clog2(TIMEOUT+1).

## Timing
- Reset (reset=0, asynchronous):
  - state=IDLE, pc=0, wait counter=0.
  - mem_rd, load_iru, load_irl, ir_valid, busy, fetch_err = 0; mem_addr=0.
- Reset asserted mid-fetch aborts immediately; no further strobes are issued.
- Deassertion takes effect at the next rising edge.
- mem_addr equals pc in all states; it is registered state, not combinational from pc_in.
- Latency with zero-wait memory (mem_ready=1 whenever mem_rd=1), start sampled at edge 0:
  - load_iru in cycle 1, load_irl in cycle 2, ir_valid in cycle 3.
- Back-to-back throughput is one instruction per 3 cycles (DONE→RD_U).
- Each wait cycle on mem_ready adds one cycle to latency.

## Test plan
- Reset, then start with zero-wait memory, mem[0]=0x12, mem[1]=0x34 → load_iru cycle 1 (addr 0), load_irl cycle 2 (addr 1), ir_valid cycle 3, pc=2, IR=0x1234.
- pc_load=1, pc_in=0xFF together with start in IDLE → reads at 0xFF then 0x00, pc=0x01 after DONE (wrap).
- mem_ready delayed 3 cycles on upper byte, TIMEOUT=15 → mem_rd held 4 cycles at the same address, a single load_iru pulse, ir_valid in cycle 6.
- mem_ready never asserted in RD_L, TIMEOUT=4 → load_iru only, fetch_err=1 after 4 wait cycles, pc restored to start address; start → full refetch from that address succeeds.
- pc_load=1, pc_in=0x40 during RD_U → ignored; the fetch completes at original addresses, pc=start+2.
- reset=0 asserted in RD_L while mem_ready=0 → all outputs 0 immediately, pc=0, no load_irl; start after release fetches from 0.
